// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
//
// Shared definitions for the bit-serial arithmetic blocks.
//   sub_state_t          : control state of the serial subtractor
//   SERIAL_DEFAULT_WIDTH : default operand width for serial datapaths
//   ref_sub()            : whole-word subtract, handy for controllers that
//                          want to cross-check a serial result
// -----------------------------------------------------------------------------
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SERIAL_DEFAULT_WIDTH = 8;

    // Returns {borrow, diff} for a 32-bit-or-narrower unsigned subtract.
    function automatic logic [32:0] ref_sub(input logic [31:0] a_val,
                                            input logic [31:0] b_val);
        return {1'b0, a_val} - {1'b0, b_val};
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//
// One-bit full subtractor cell computing a - b - b_in.
//   a     in  minuend bit
//   b     in  subtrahend bit
//   b_in  in  incoming borrow
//   d     out difference bit
//   b_out out outgoing borrow
// Purely combinational.
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    // Borrow when b exceeds a outright, or when they are equal and a borrow
    // is already pending from the lower bit.
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor: diff = (a - b) mod 2^WIDTH, one bit per
// clock, LSB first, through a single full_subtractor and a borrow flip-flop.
//
//   clk         in  rising-edge clock
//   rst         in  synchronous active-high reset
//   start       in  request, only honoured in IDLE
//   a, b        in  operands, captured on the accepting edge
//   busy        out high while processing bits (state RUN)
//   done        out one-cycle pulse when diff/borrow_out are valid
//   diff        out result register (partial data while busy)
//   borrow_out  out final borrow, 1 iff a < b unsigned
//
// A request accepted at edge k produces done in the cycle after edge
// k+WIDTH; the next request can be accepted at edge k+WIDTH+2.
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_t       state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] res_reg;
    logic             borrow_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             d_bit;
    logic             bout_bit;

    full_subtractor u_fs (
        .a     (a_sr_reg[0]),
        .b     (b_sr_reg[0]),
        .b_in  (borrow_reg),
        .d     (d_bit),
        .b_out (bout_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sr_reg   <= a;
                        b_sr_reg   <= b;
                        res_reg    <= '0;
                        borrow_reg <= 1'b0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end

                RUN: begin
                    a_sr_reg   <= a_sr_reg >> 1;
                    b_sr_reg   <= b_sr_reg >> 1;
                    // Result fills from the top so bit 0 ends up at LSB
                    // after WIDTH shifts.
                    res_reg    <= {d_bit, res_reg[WIDTH-1:1]};
                    borrow_reg <= bout_bit;
                    if (cnt_reg == LAST_BIT) begin
                        // Counter is left at its last value rather than
                        // wrapping; it is cleared on the next accept.
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign diff       = res_reg;
    assign borrow_out = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor: an 8-bit instance for the handshake,
// latency, ignored-start and reset cases, and a 4-bit instance swept over
// all operand pairs.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    int checks   = 0;
    int failures = 0;
    int done4_cnt = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (borrow8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow4)
    );

    // Every done pulse from the 4-bit instance; compared against the number
    // of requests issued to it at the end.
    always @(posedge clk) begin
        if (done4) done4_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One 8-bit request with operands scrambled right after the sampling edge.
    task automatic do_sub8(input string tag, input logic [7:0] ta,
                           input logic [7:0] tb_v, input logic [7:0] exp_d,
                           input logic exp_b);
        int n;
        int bc;
        a8 = ta;
        b8 = tb_v;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = ~ta;
        b8 = ~tb_v;
        n = 0;
        bc = 0;
        while (!done8 && n < 20) begin
            if (busy8) bc++;
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_busy_cycles"}, bc, 8);
        check({tag, "_diff"}, diff8, exp_d);
        check({tag, "_borrow"}, borrow8, exp_b);
        tick();
        check({tag, "_done_drop"}, done8, 0);
        check({tag, "_diff_hold"}, diff8, exp_d);
    endtask

    initial begin
        int n;
        logic [4:0] exp5;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_borrow", borrow8, 0);

        // Basic and underflow cases
        do_sub8("basic", 8'h5A, 8'h23, 8'h37, 1'b0);
        do_sub8("under", 8'h00, 8'h01, 8'hFF, 1'b1);
        do_sub8("equal", 8'hFF, 8'hFF, 8'h00, 1'b0);

        // start held high; operands garbage except at the two IDLE sampling
        // edges (0 and 10). Edge 9 is in DONE, so a garbage accept there
        // would move the second done to edge 17.
        for (int t = 0; t < 20; t++) begin
            start8 = 1'b1;
            if (t == 0) begin
                a8 = 8'h10; b8 = 8'h01;
            end else if (t == 10) begin
                a8 = 8'h33; b8 = 8'h44;
            end else begin
                a8 = 8'(t * 29 + 3);
                b8 = 8'(t * 71 + 5);
            end
            tick();
            check($sformatf("hold_done_t%0d", t), done8, (t == 8 || t == 18));
            if (t == 8) begin
                check("hold_diff1", diff8, 8'h0F);
                check("hold_borrow1", borrow8, 0);
            end
            if (t == 18) begin
                check("hold_diff2", diff8, 8'hEF);
                check("hold_borrow2", borrow8, 1);
            end
        end
        start8 = 1'b0;
        tick();
        tick();
        check("hold_idle_busy", busy8, 0);

        // Reset three cycles into RUN
        a8 = 8'h5A; b8 = 8'h23; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", busy8, 0);
        check("mrst_done", done8, 0);
        check("mrst_diff", diff8, 0);
        check("mrst_borrow", borrow8, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) n++;
            tick();
        end
        check("mrst_no_done", n, 0);
        do_sub8("after_rst", 8'h80, 8'h7F, 8'h01, 1'b0);

        // Reset and start on the same edge
        rst = 1'b1; start8 = 1'b1; a8 = 8'h44; b8 = 8'h11;
        tick();
        rst = 1'b0; start8 = 1'b0;
        check("coll_busy", busy8, 0);
        tick();
        check("coll_busy2", busy8, 0);
        check("coll_done", done8, 0);

        // Exhaustive sweep on the 4-bit instance
        done4_cnt = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                a4 = 4'(ia);
                b4 = 4'(ib);
                start4 = 1'b1;
                tick();
                start4 = 1'b0;
                a4 = 4'(ib);
                b4 = 4'(ia);
                n = 0;
                while (!done4 && n < 12) begin
                    tick();
                    n++;
                end
                exp5 = {1'b0, 4'(ia)} - {1'b0, 4'(ib)};
                check($sformatf("w4_lat_%0h_%0h", ia, ib), n, 4);
                check($sformatf("w4_res_%0h_%0h", ia, ib), {borrow4, diff4}, exp5);
                tick();
            end
        end
        tick();
        tick();
        check("w4_done_count", done4_cnt, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
